// File: rtl/cpu_mul_wb_tracker.sv
// cpu_mul_wb_tracker: write-back scoreboard for the DEPTH-stage multiplier pipe.
// Each stage holds {write_back, rd_id}; decode reads all stages for RAW/WAW
// hazard checks, and the oldest entry produces a one-cycle retire pulse that
// issues the register file write.
// Optional feature macro: CPU_MUL_OCCUPANCY_EN adds the occupancy counter and
// the full flag.
// Legal DEPTH range is 2..8.

module cpu_mul_wb_tracker #(
    parameter int DEPTH = 5,
    parameter int REG_W = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     advance,
    input  logic                     issue_valid,
    input  logic                     issue_wb,
    input  logic [REG_W-1:0]         issue_rd,
    input  logic                     flush,
    output logic                     issue_accept,
    output logic [DEPTH-1:0]         mul_wb_valid,
    output logic [DEPTH*REG_W-1:0]   mul_wb_rd,
    output logic                     retire_valid,
    output logic [REG_W-1:0]         retire_rd,
    output logic                     busy
`ifdef CPU_MUL_OCCUPANCY_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    output logic                     full
`endif
);

    logic [DEPTH-1:0] stage_valid;
    logic [REG_W-1:0] stage_rd [DEPTH];
    logic             load;

    assign issue_accept = issue_valid & advance & ~flush;

    // r0 writes and non-writing multiplies never create a hazard, so they
    // enter the pipe as empty slots.
    assign load = issue_accept & issue_wb & (issue_rd != '0);

    // Shift register of tracked entries plus the registered retire pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_valid  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                stage_rd[i] <= '0;
            end
            retire_valid <= 1'b0;
            retire_rd    <= '0;
        end else if (advance) begin
            stage_valid <= {stage_valid[DEPTH-2:0], load};
            stage_rd[0] <= load ? issue_rd : '0;
            for (int i = 1; i < DEPTH; i++) begin
                stage_rd[i] <= stage_rd[i-1];
            end
            retire_valid <= stage_valid[DEPTH-1];
            retire_rd    <= stage_rd[DEPTH-1];
        end else begin
            // Held stages must not re-issue the write on every stalled cycle.
            retire_valid <= 1'b0;
        end
    end

    // Flatten the rd fields straight from the flops for the hazard unit.
    always_comb begin
        mul_wb_rd = '0;
        for (int i = 0; i < DEPTH; i++) begin
            mul_wb_rd[i*REG_W +: REG_W] = stage_rd[i];
        end
    end

    assign mul_wb_valid = stage_valid;
    assign busy         = |stage_valid;

`ifdef CPU_MUL_OCCUPANCY_EN
    localparam int OCC_W = $clog2(DEPTH+1);

    // Running count of valid stages, kept in step with the shift register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occupancy <= '0;
        end else if (advance) begin
            case ({load, stage_valid[DEPTH-1]})
                2'b10:   occupancy <= occupancy + OCC_W'(1);
                2'b01:   occupancy <= occupancy - OCC_W'(1);
                default: occupancy <= occupancy;
            endcase
        end
    end

    assign full = (occupancy == OCC_W'(DEPTH));

    a_occupancy_matches : assert property (
        @(posedge clk) disable iff (!rst_n)
        occupancy == OCC_W'($countones(stage_valid))
    );
`endif

endmodule

// File: doc/cpu_mul_wb_tracker.md
Name: cpu_mul_wb_tracker

Overview:
- Producer of the multiplier write-back scoreboard consumed by the hazard detection unit.
- Tracks every multiply in flight through the DEPTH-stage multiplier pipe as a {write_back, rd_id} entry per stage.
- Exports all entries so decode can detect RAW/WAW hazards against pending multiplies.
- Signals retirement when an entry leaves the last stage so the register file write is issued.
- Sits beside the execute-stage multiplier.
- Advances in lock-step with the multiplier datapath.

Parameters:
- DEPTH, 5, number of multiplier pipeline stages, i.e. number of tracked entries. Legal range 2..8.
- REG_W, 5, register-id width.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- advance  in  1  pipe moves one stage this cycle. Driven as the inverse of the global execute stall.
- issue_valid  in  1  a multiply enters stage 0 this cycle.
- issue_wb  in  1  the issued multiply writes a register.
- issue_rd  in  REG_W  destination register of the issued multiply.
- flush  in  1  kill the multiply being issued this cycle (branch/jump squash).
- issue_accept  out  1  combinational: issue_valid & advance & ~flush.
- mul_wb_valid  out  DEPTH  per-stage write_back flag. Bit 0 is the youngest entry.
- mul_wb_rd  out  DEPTH*REG_W  per-stage rd_id. Stage i occupies bits [i*REG_W +: REG_W].
- retire_valid  out  1  registered: the oldest entry writes back this cycle.
- retire_rd  out  REG_W  registered: destination register of the retiring entry.
- busy  out  1  combinational: OR of mul_wb_valid.

Behaviour:
- Reset:
  - rst_n low clears all stage valid bits, all rd fields, retire_valid and retire_rd to 0 immediately, without waiting for a clock.
  - Reset asserted mid-operation discards every in-flight entry; no retire pulse is produced for discarded entries.
- Entry load on a clock edge with advance=1:
  - Stage 0 valid <= issue_accept & issue_wb & (issue_rd != 0). Writes to r0 are never tracked.
  - Stage 0 rd <= issue_rd when that load condition is true, else 0.
  - For 1 <= i < DEPTH, stage i <= stage i-1.
- Retirement on a clock edge with advance=1:
  - retire_valid <= stage DEPTH-1 valid; retire_rd <= stage DEPTH-1 rd.
  - Net effect: the register file write occurs exactly DEPTH+1 edges after issue, counting the issue edge as 1.
  - Stage DEPTH-1 shifts out and is lost.
- advance=0 (stall):
  - Every stage holds.
  - retire_valid <= 0, so the write happens once, not repeatedly.
  - issue_accept is 0 and any issue is ignored. The upstream stage must hold the instruction.
- flush=1 with issue_valid=1 and advance=1: nothing is written to stage 0; older entries still shift and retire normally.
- Simultaneous issue and retire: both happen in the same cycle with no interaction.
  - An entry whose rd matches the retiring rd is independent and tracked normally.
- Duplicate rd across stages is legal: each entry retires separately, in order.
- rd field of an invalid stage is always 0, which guarantees no false hazard match.
- No combinational path from stage registers to inputs. mul_wb_valid and mul_wb_rd come straight from flops.

Optional Feature:
- Macro: CPU_MUL_OCCUPANCY_EN.
- With the macro defined:
  - Adds output occupancy, width $clog2(DEPTH+1): a registered count of valid stages.
  - Update on an advance edge: +1 if an entry loads, -1 if stage DEPTH-1 was valid, net 0 if both.
  - Unchanged when advance=0. Reset value 0.
  - Adds output full, combinational: occupancy==DEPTH.
  - Simulation assertion: occupancy == popcount(mul_wb_valid) every cycle.
- Without the macro: neither port nor counter exists; busy is still provided.

Test Plan:
- Single issue: issue rd=7 wb=1 at cycle 0 with advance=1 throughout.
  - Required: mul_wb_valid walks 00001 -> 10000 over 5 edges.
  - Required: retire_valid=1 with retire_rd=7 for exactly one cycle after edge 6; busy=0 afterwards.
- r0/no-wb filter: issue rd=0 wb=1, then rd=3 wb=0 -> mul_wb_valid stays 0, no retire pulse.
- Stall mid-flight: issue rd=9, then advance=0 for 3 cycles while the entry is at stage 2.
  - Required: entry holds at stage 2 and issue_accept=0 during the stall.
  - Required: retire pulse is delayed by exactly 3 cycles and is a single cycle.
- Back-to-back: issue rd=1..5 on 5 consecutive cycles, then rd=6 as rd=1 retires.
  - Required: all 5 valid bits set (occupancy=5, full=1 if enabled).
  - Required: retires occur in order 1,2,3,4,5 on consecutive cycles.
- Flush: issue rd=4 with flush=1 while rd=2 sits at stage 1 -> stage 0 stays empty; rd=2 still retires on time.
- Async reset: pulse rst_n low between clock edges with 3 entries in flight.
  - Required: all outputs go to 0 immediately with no retire pulse.
  - Required: a fresh issue after release behaves as in the single-issue scenario.
